// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, count-up and clear,
// with a shift-progress counter that flags DONE after WIDTH shift/rotate steps.
module shift_reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic [2:0]                   MODE,
    input  logic [WIDTH-1:0]             D,
    input  logic                         SI_L,
    input  logic                         SI_R,
    output logic [WIDTH-1:0]             Q,
    output logic [WIDTH-1:0]             QN,
    output logic                         SO_L,
    output logic                         SO_R,
    output logic [$clog2(WIDTH+1)-1:0]   CNT,
    output logic                         DONE,
    output logic                         CARRY,
    output logic [1:0]                   DBG_STATE
);

    localparam int CW = $clog2(WIDTH+1);

    localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_CNT   = 3'b110;
    localparam logic [2:0] M_CLR   = 3'b111;

    // Progress-counter state; always consistent with cnt_q (0, 1..WIDTH-1, WIDTH).
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_FULL     = 2'd2
    } state_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    state_e           state_q, state_d;
    logic             shift_op;

    assign shift_op = EN && (MODE == M_SHL || MODE == M_SHR ||
                             MODE == M_ROL || MODE == M_ROR);

    // Datapath next state
    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (EN) begin
            case (MODE)
                M_HOLD: q_d = q_q;
                M_LOAD: begin
                    q_d     = D;
                    carry_d = 1'b0;
                end
                M_SHL:  q_d = {q_q[WIDTH-2:0], SI_L};
                M_SHR:  q_d = {SI_R, q_q[WIDTH-1:1]};
                M_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                M_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                M_CNT: begin
                    q_d     = q_q + Q_ONE;
                    carry_d = &q_q;
                end
                M_CLR: begin
                    q_d     = '0;
                    carry_d = 1'b0;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Progress FSM next state; cnt saturates at WIDTH
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (EN && (MODE == M_LOAD || MODE == M_CLR)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (shift_op) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = (cnt_q == CNT_LAST) ? ST_FULL : ST_SHIFTING;
                    cnt_d   = cnt_q + CNT_ONE;
                end
                ST_SHIFTING: begin
                    state_d = (cnt_q == CNT_LAST) ? ST_FULL : ST_SHIFTING;
                    cnt_d   = cnt_q + CNT_ONE;
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                    cnt_d   = CNT_MAX;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            state_q <= state_d;
        end
    end

    assign Q         = q_q;
    assign QN        = ~q_q;
    assign SO_L      = q_q[WIDTH-1];
    assign SO_R      = q_q[0];
    assign CNT       = cnt_q;
    assign DONE      = (cnt_q == CNT_MAX);
    assign CARRY     = carry_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, RESET_VAL=8'hA5) with
// hand-computed expectations per scenario.
module tb_shift_reg_univ;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si_l;
    logic       si_r;
    logic [7:0] q;
    logic [7:0] qn;
    logic       so_l;
    logic       so_r;
    logic [3:0] cnt;
    logic       done;
    logic       carry;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .D(d),
        .SI_L(si_l), .SI_R(si_r), .Q(q), .QN(qn), .SO_L(so_l), .SO_R(so_r),
        .CNT(cnt), .DONE(done), .CARRY(carry), .DBG_STATE(dbg_state)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are then driven 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 3'b000; d = 8'h00; si_l = 1'b0; si_r = 1'b0;
        tick(); tick();
        rst = 1'b0; mode = 3'b001; d = 8'h00;
        tick();
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL pre_reset_load q=%h exp=00", q); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_q q=%h exp=a5", q); end
        n_checks++; if (qn !== 8'h5A) begin n_fail++; $display("FAIL reset_qn qn=%h exp=5a", qn); end
        n_checks++; if (cnt !== 4'd0 || done !== 1'b0 || carry !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt cnt=%0d done=%b carry=%b exp=0/0/0", cnt, done, carry); end
        n_checks++; if (so_l !== 1'b1 || so_r !== 1'b1) begin
            n_fail++; $display("FAIL reset_so so_l=%b so_r=%b exp=1/1", so_l, so_r); end
        mode = 3'b110;
        tick(); tick(); tick();
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_hold q=%h exp=a5", q); end
        rst = 1'b0;
        tick();
        n_checks++; if (q !== 8'hA6) begin n_fail++; $display("FAIL release_first_edge q=%h exp=a6", q); end
    endtask

    task automatic test_serialiser();
        logic [7:0] so_exp;
        so_exp = 8'b1011_0010;
        mode = 3'b001; d = 8'b1011_0010;
        tick();
        mode = 3'b010; si_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (so_l !== so_exp[7-i]) begin
                n_fail++; $display("FAIL ser_so_l[%0d] so_l=%b exp=%b", i, so_l, so_exp[7-i]); end
            if (i == 7) begin
                n_checks++; if (cnt !== 4'd7 || done !== 1'b0) begin
                    n_fail++; $display("FAIL ser_pre_done cnt=%0d done=%b exp=7/0", cnt, done); end
            end
            tick();
        end
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL ser_q q=%h exp=00", q); end
        n_checks++; if (cnt !== 4'd8 || done !== 1'b1) begin
            n_fail++; $display("FAIL ser_done cnt=%0d done=%b exp=8/1", cnt, done); end
        n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL ser_state st=%0d exp=2", dbg_state); end
        tick();
        n_checks++; if (cnt !== 4'd8 || done !== 1'b1) begin
            n_fail++; $display("FAIL ser_saturate cnt=%0d done=%b exp=8/1", cnt, done); end
        mode = 3'b001; d = 8'h5A;
        tick();
        n_checks++; if (q !== 8'h5A || cnt !== 4'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL load_when_done q=%h cnt=%0d done=%b exp=5a/0/0", q, cnt, done); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL load_state st=%0d exp=0", dbg_state); end
    endtask

    task automatic test_deserialiser();
        logic [7:0] si_seq;
        si_seq = 8'b1001_1101;
        mode = 3'b111;
        tick();
        n_checks++; if (q !== 8'h00 || cnt !== 4'd0) begin
            n_fail++; $display("FAIL des_clear q=%h cnt=%0d exp=00/0", q, cnt); end
        mode = 3'b011;
        for (int i = 0; i < 8; i++) begin
            si_r = si_seq[7-i];
            if (i == 7) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL des_early_done done=%b exp=0", done); end
            end
            tick();
        end
        n_checks++; if (q !== 8'b1011_1001) begin n_fail++; $display("FAIL des_q q=%h exp=b9", q); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL des_done done=%b exp=1", done); end
        n_checks++; if (qn !== 8'h46) begin n_fail++; $display("FAIL des_qn qn=%h exp=46", qn); end
    endtask

    task automatic test_rotate();
        mode = 3'b001; d = 8'h81;
        tick();
        mode = 3'b100;
        tick();
        n_checks++; if (q !== 8'h03) begin n_fail++; $display("FAIL rol q=%h exp=03", q); end
        mode = 3'b101;
        tick();
        n_checks++; if (q !== 8'h81) begin n_fail++; $display("FAIL ror1 q=%h exp=81", q); end
        tick();
        n_checks++; if (q !== 8'hC0) begin n_fail++; $display("FAIL ror2 q=%h exp=c0", q); end
        n_checks++; if (cnt !== 4'd3 || dbg_state !== 2'd1) begin
            n_fail++; $display("FAIL rot_cnt cnt=%0d st=%0d exp=3/1", cnt, dbg_state); end
        n_checks++; if (so_l !== 1'b1 || so_r !== 1'b0) begin
            n_fail++; $display("FAIL rot_so so_l=%b so_r=%b exp=1/0", so_l, so_r); end
    endtask

    task automatic test_counter();
        mode = 3'b001; d = 8'hFE;
        tick();
        mode = 3'b110;
        tick();
        n_checks++; if (q !== 8'hFF || carry !== 1'b0) begin
            n_fail++; $display("FAIL cnt_ff q=%h carry=%b exp=ff/0", q, carry); end
        tick();
        n_checks++; if (q !== 8'h00 || carry !== 1'b1) begin
            n_fail++; $display("FAIL cnt_wrap q=%h carry=%b exp=00/1", q, carry); end
        tick();
        n_checks++; if (q !== 8'h01 || carry !== 1'b0) begin
            n_fail++; $display("FAIL cnt_01 q=%h carry=%b exp=01/0", q, carry); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_progress cnt=%0d exp=0", cnt); end
        // CARRY survives shifts and holds, cleared by clear
        mode = 3'b001; d = 8'hFF;
        tick();
        mode = 3'b110;
        tick();
        mode = 3'b010; si_l = 1'b1;
        tick();
        mode = 3'b000;
        tick();
        n_checks++; if (carry !== 1'b1 || q !== 8'h01 || cnt !== 4'd1) begin
            n_fail++; $display("FAIL carry_sticky carry=%b q=%h cnt=%0d exp=1/01/1", carry, q, cnt); end
        mode = 3'b111;
        tick();
        n_checks++; if (carry !== 1'b0 || q !== 8'h00 || cnt !== 4'd0) begin
            n_fail++; $display("FAIL clear_all carry=%b q=%h cnt=%0d exp=0/00/0", carry, q, cnt); end
    endtask

    task automatic test_enable_async_reset();
        mode = 3'b001; d = 8'h3C;
        tick();
        en = 1'b0; mode = 3'b010; si_l = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++; if (q !== 8'h3C || cnt !== 4'd0) begin
            n_fail++; $display("FAIL en_freeze q=%h cnt=%0d exp=3c/0", q, cnt); end
        en = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (q !== 8'hE0 || cnt !== 4'd3) begin
            n_fail++; $display("FAIL en_shift q=%h cnt=%0d exp=e0/3", q, cnt); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (q !== 8'hA5 || cnt !== 4'd0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL async_reset q=%h cnt=%0d st=%0d exp=a5/0/0", q, cnt, dbg_state); end
        tick();
        rst = 1'b0; mode = 3'b000;
        tick();
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL hold_after_reset q=%h exp=a5", q); end
    endtask

    initial begin
        test_reset();
        test_serialiser();
        test_deserialiser();
        test_rotate();
        test_counter();
        test_enable_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

- Parametrised universal register, the next generation of the team's single-bit D flip-flop with true and complement outputs.
- WIDTH bits wide, with eight selectable modes: hold, parallel load, logical shift left/right, rotate left/right, count up and synchronous clear.
- A shift-progress counter asserts DONE after WIDTH shift/rotate operations, so the block serves as a serialiser/deserialiser and general-purpose state register in datapath designs.

## Interface
Parameters:
- WIDTH, 8, register width in bits; minimum 2.
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  clock enable; when 0 every mode acts as hold.
- MODE  input  3  operation select (see Operation).
- D  input  WIDTH  parallel load data.
- SI_L  input  1  serial input entering bit 0 on shift left.
- SI_R  input  1  serial input entering bit WIDTH-1 on shift right.
- Q  output  WIDTH  register contents.
- QN  output  WIDTH  bitwise complement of Q, always ~Q, including during reset.
- SO_L  output  1  Q[WIDTH-1], bit leaving on shift left.
- SO_R  output  1  Q[0], bit leaving on shift right.
- CNT  output  clog2(WIDTH+1)  shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- DONE  output  1  high when CNT == WIDTH.
- CARRY  output  1  registered carry out of the last count-up wrap.

## Operation
- The mode is applied only when EN=1:
  - 000 hold: Q unchanged.
  - 001 load: Q <= D, CNT <= 0, CARRY <= 0.
  - 010 shift left: Q <= {Q[WIDTH-2:0], SI_L}.
  - 011 shift right: Q <= {SI_R, Q[WIDTH-1:1]}.
  - 100 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 101 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 110 count up: Q <= Q+1, modulo 2^WIDTH. CARRY <= 1 only on the all-ones to zero wrap, otherwise 0.
  - 111 clear: Q <= 0, CNT <= 0, CARRY <= 0 (synchronous; distinct from RST, which loads RESET_VAL).
- CNT increments by 1 on each enabled shift or rotate (modes 010–101) while CNT < WIDTH, and holds at WIDTH after that.
- CNT is unaffected by hold and count-up.
- CARRY is unaffected by all modes other than load, count-up and clear.
- DONE is combinational from CNT, so it tracks the registered count.
- SO_L, SO_R and QN are combinational from Q.
- State machine for the progress counter:
  - IDLE (CNT=0) -> SHIFTING (0<CNT<WIDTH) on the first shift/rotate.
  - SHIFTING -> FULL (CNT=WIDTH) on the WIDTH-th shift/rotate.
  - Any state -> IDLE on load, clear or RST.
  - FULL persists under further shifts.

## Timing
- Reset: on RST rising, immediately and independent of CLK:
  - Q=RESET_VAL, QN=~RESET_VAL, CNT=0, DONE=0, CARRY=0.
  - SO_L/SO_R reflect RESET_VAL.
- While RST=1 all edges are ignored.
- Release: the first rising edge with RST=0 performs the selected operation.
- RST asserted mid-shift aborts the operation and clears CNT; there is no partial-state retention.
- Latency: one cycle from the MODE/D/SI sample at the rising edge to the updated Q. QN, SO_L, SO_R and DONE are valid in the same cycle as Q.
- EN=0 freezes Q, CNT and CARRY regardless of MODE.
- Inputs change only away from the rising edge, with setup/hold met. MODE may change every cycle with no dead cycle between modes.
- Boundary cases:
  - WIDTH=2: rotate swaps the two bits.
  - Count up from 2^WIDTH-1 gives 0 with CARRY=1. The next count-up gives CARRY=0.
  - Load in the same cycle DONE=1 clears CNT and DONE on the next edge.

## Test plan
WIDTH=8, RESET_VAL=8'hA5, 10 ns clock, EN=1 unless stated.
- Reset: assert RST between edges -> Q=8'hA5, QN=8'h5A immediately, CNT=0, DONE=0. Hold RST across 3 edges with MODE=110 -> Q stays 8'hA5.
- Serialiser: load D=8'b1011_0010, then 8 shift-left edges with SI_L=0 -> SO_L sequence 1,0,1,1,0,0,1,0 sampled before each edge; after 8 edges Q=0, CNT=8, DONE=1. Ninth shift -> CNT stays 8.
- Deserialiser: clear, then 8 shift-right edges with SI_R=1,0,0,1,1,1,0,1 -> Q=8'b1011_1001, DONE=1 on the 8th edge.
- Rotate: load 8'h81, rotate left once -> 8'h03; rotate right twice -> 8'hC0; CNT=3.
- Counter: load 8'hFE, count 3 edges -> Q=8'hFF, 8'h00 (CARRY=1), 8'h01 (CARRY=0); CNT unchanged at 0.
- Enable and async reset: load 8'h3C, then EN=0 with MODE=010 for 4 edges -> Q=8'h3C, CNT=0. EN=1 for 3 shifts, then RST pulse mid-cycle -> Q=8'hA5, CNT=0 without waiting for an edge.
